// File: rtl/sb_pkg.sv
// Shared types and constants for the multi-FU scoreboard: FU indices, per-FU status record,
// and the field widths that the status record is built from.
package sb_pkg;

  localparam int N_FU_DEFAULT  = 5;
  localparam int N_REG_DEFAULT = 32;

  // Status fields are sized for the default core; N_FU must stay within 2**FU_FIELD_W-1.
  localparam int FU_FIELD_W  = $clog2(N_FU_DEFAULT);
  localparam int REG_FIELD_W = $clog2(N_REG_DEFAULT);

  localparam logic [FU_FIELD_W-1:0] FU_ALU  = 3'd0;
  localparam logic [FU_FIELD_W-1:0] FU_MEM  = 3'd1;
  localparam logic [FU_FIELD_W-1:0] FU_MUL  = 3'd2;
  localparam logic [FU_FIELD_W-1:0] FU_DIV  = 3'd3;
  localparam logic [FU_FIELD_W-1:0] FU_JUMP = 3'd4;
  localparam logic [FU_FIELD_W-1:0] NO_FU   = '1;

  typedef struct packed {
    logic                   busy;
    logic                   op_read;
    logic [REG_FIELD_W-1:0] fi;
    logic                   fi_v;
    logic [REG_FIELD_W-1:0] fj;
    logic [REG_FIELD_W-1:0] fk;
    logic [FU_FIELD_W-1:0]  qj;
    logic [FU_FIELD_W-1:0]  qk;
    logic                   qj_v;
    logic                   qk_v;
    logic                   rj;
    logic                   rk;
  } fu_status_t;

endpackage

// File: rtl/sb_wb_arbiter.sv
// Writeback arbiter: picks one eligible FU per cycle. SB_RR_WB_EN selects round-robin
// (pointer moves to granted+1); otherwise the lowest eligible index wins.
module sb_wb_arbiter
#(
  parameter int N_FU = 5
) (
`ifdef SB_RR_WB_EN
  input  logic            clk,
  input  logic            rst,
`endif
  input  logic [N_FU-1:0] i_eligible,
  output logic [N_FU-1:0] o_grant
);

`ifdef SB_RR_WB_EN
  localparam int PW = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_found;

  // Search starts at the pointer and wraps, so the last winner drops to lowest priority.
  always_comb begin
    o_grant    = '0;
    w_found    = 1'b0;
    w_next_ptr = r_ptr;
    for (int k = 0; k < N_FU; k++) begin
      if (!w_found && i_eligible[(int'(r_ptr) + k) % N_FU]) begin
        o_grant[(int'(r_ptr) + k) % N_FU] = 1'b1;
        w_next_ptr = PW'(((int'(r_ptr) + k) % N_FU + 1) % N_FU);
        w_found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_next_ptr;
    end
  end
`else
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_FU; i++) begin
      if (!w_found && i_eligible[i]) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/scoreboard_ctrl.sv
// Scoreboard for the multi-FU RV32 core: issue gating (structural/WAW), operand-read grants (RAW),
// and one WAR-safe writeback per cycle. Define SB_RR_WB_EN for round-robin writeback arbitration.
module scoreboard_ctrl
  import sb_pkg::*;
#(
  parameter int N_FU  = N_FU_DEFAULT,
  parameter int N_REG = N_REG_DEFAULT,
  parameter int FU_W  = $clog2(N_FU),
  parameter int REG_W = $clog2(N_REG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [FU_W-1:0]  issue_fu,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_reg_write,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic             issue_use_rs1,
  input  logic             issue_use_rs2,
  output logic             issue_ready,
  output logic [N_FU-1:0]  ro_grant,
  input  logic [N_FU-1:0]  fu_done,
  output logic [N_FU-1:0]  wb_grant,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_rd,
  output logic [N_FU-1:0]  busy_o
);

  // Handshakes: an instruction transfers on an edge where issue_valid & issue_ready; ro_grant is a
  // one-cycle pulse; fu_done[i] is held by the FU until the cycle it sees wb_grant[i].

  fu_status_t             r_fu [N_FU];
  logic [N_REG-1:0]       r_rrs_v;
  logic [FU_FIELD_W-1:0]  r_rrs [N_REG];

  logic [N_FU-1:0]        w_busy;
  logic [2**FU_W-1:0]     w_busy_pad;
  logic                   w_rd_pending;
  logic                   w_issue_ready;
  logic                   w_qj_v;
  logic                   w_qk_v;
  fu_status_t             w_new;
  logic [N_FU-1:0]        w_ro_grant;
  logic [N_FU-1:0]        w_war;
  logic [N_FU-1:0]        w_eligible;
  logic [N_FU-1:0]        w_wb_grant;
  logic                   w_wb_any;
  logic [FU_FIELD_W-1:0]  w_wb_idx;
  logic [REG_FIELD_W-1:0] w_wb_fi;
  logic                   w_wb_fi_v;

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < N_FU; i++) w_busy[i] = r_fu[i].busy;
  end

  // Out-of-range FU indices read as busy so they can never be accepted.
  always_comb begin
    w_busy_pad           = '1;
    w_busy_pad[N_FU-1:0] = w_busy;
  end

  assign w_rd_pending  = issue_reg_write & (issue_rd != '0) & r_rrs_v[issue_rd];
  assign w_issue_ready = issue_valid & ~w_busy_pad[issue_fu] & ~w_rd_pending;

  // A producer being written back this very cycle no longer blocks the new consumer.
  assign w_qj_v = issue_use_rs1 & (issue_rs1 != '0) & r_rrs_v[issue_rs1]
                & ~(w_wb_any & (r_rrs[issue_rs1] == w_wb_idx));
  assign w_qk_v = issue_use_rs2 & (issue_rs2 != '0) & r_rrs_v[issue_rs2]
                & ~(w_wb_any & (r_rrs[issue_rs2] == w_wb_idx));

  always_comb begin
    w_new         = '0;
    w_new.busy    = 1'b1;
    w_new.op_read = 1'b0;
    w_new.fi      = REG_FIELD_W'(issue_rd);
    w_new.fi_v    = issue_reg_write & (issue_rd != '0);
    w_new.fj      = REG_FIELD_W'(issue_rs1);
    w_new.fk      = REG_FIELD_W'(issue_rs2);
    w_new.qj      = r_rrs[issue_rs1];
    w_new.qk      = r_rrs[issue_rs2];
    w_new.qj_v    = w_qj_v;
    w_new.qk_v    = w_qk_v;
    w_new.rj      = ~w_qj_v;
    w_new.rk      = ~w_qk_v;
  end

  always_comb begin
    w_ro_grant = '0;
    w_war      = '0;
    w_eligible = '0;
    for (int i = 0; i < N_FU; i++) begin
      w_ro_grant[i] = r_fu[i].busy & ~r_fu[i].op_read & r_fu[i].rj & r_fu[i].rk;
      // FU i must not overwrite a register some other FU still has to read.
      for (int j = 0; j < N_FU; j++) begin
        if (j != i && r_fu[j].busy && !r_fu[j].op_read &&
            (((r_fu[j].fj == r_fu[i].fi) && r_fu[j].rj) ||
             ((r_fu[j].fk == r_fu[i].fi) && r_fu[j].rk))) begin
          w_war[i] = 1'b1;
        end
      end
      w_eligible[i] = r_fu[i].busy & r_fu[i].op_read & fu_done[i] & ~w_war[i];
    end
  end

  sb_wb_arbiter #(.N_FU(N_FU)) u_wb_arbiter (
`ifdef SB_RR_WB_EN
    .clk        (clk),
    .rst        (rst),
`endif
    .i_eligible (w_eligible),
    .o_grant    (w_wb_grant)
  );

  always_comb begin
    w_wb_idx  = NO_FU;
    w_wb_fi   = '0;
    w_wb_fi_v = 1'b0;
    for (int i = 0; i < N_FU; i++) begin
      if (w_wb_grant[i]) begin
        w_wb_idx  = FU_FIELD_W'(i);
        w_wb_fi   = r_fu[i].fi;
        w_wb_fi_v = r_fu[i].fi_v;
      end
    end
  end

  assign w_wb_any = |w_wb_grant;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_FU; i++) r_fu[i] <= '0;
      for (int r = 0; r < N_REG; r++) r_rrs[r] <= '0;
      r_rrs_v <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (w_ro_grant[i]) begin
          r_fu[i].op_read <= 1'b1;
          r_fu[i].rj      <= 1'b0;
          r_fu[i].rk      <= 1'b0;
        end
        if (w_wb_any && r_fu[i].qj_v && (r_fu[i].qj == w_wb_idx)) begin
          r_fu[i].rj   <= 1'b1;
          r_fu[i].qj_v <= 1'b0;
        end
        if (w_wb_any && r_fu[i].qk_v && (r_fu[i].qk == w_wb_idx)) begin
          r_fu[i].rk   <= 1'b1;
          r_fu[i].qk_v <= 1'b0;
        end
        if (w_wb_grant[i]) r_fu[i].busy <= 1'b0;
        if (w_issue_ready && (issue_fu == FU_W'(i))) r_fu[i] <= w_new;
      end
      if (w_wb_any && w_wb_fi_v && (r_rrs[w_wb_fi] == w_wb_idx)) r_rrs_v[w_wb_fi] <= 1'b0;
      // Issue is applied last so a fresh claim on rd wins over a same-cycle release.
      if (w_issue_ready && w_new.fi_v) begin
        r_rrs[issue_rd]   <= FU_FIELD_W'(issue_fu);
        r_rrs_v[issue_rd] <= 1'b1;
      end
    end
  end

  assign issue_ready = w_issue_ready;
  assign ro_grant    = w_ro_grant;
  assign wb_grant    = w_wb_grant;
  assign wb_en       = w_wb_any & w_wb_fi_v;
  assign wb_rd       = REG_W'(w_wb_fi);
  assign busy_o      = w_busy;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl: reset, RAW, WAW/structural, WAR, arbitration, x0 and bypass,
// plus an in-order queue of expected writeback registers.
module tb_scoreboard_ctrl;
  import sb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [2:0] issue_fu;
  logic [4:0] issue_rd;
  logic       issue_reg_write;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic       issue_use_rs1;
  logic       issue_use_rs2;
  logic       issue_ready;
  logic [4:0] ro_grant;
  logic [4:0] fu_done;
  logic [4:0] wb_grant;
  logic       wb_en;
  logic [4:0] wb_rd;
  logic [4:0] busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  scoreboard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_fu        (issue_fu),
    .issue_rd        (issue_rd),
    .issue_reg_write (issue_reg_write),
    .issue_rs1       (issue_rs1),
    .issue_rs2       (issue_rs2),
    .issue_use_rs1   (issue_use_rs1),
    .issue_use_rs2   (issue_use_rs2),
    .issue_ready     (issue_ready),
    .ro_grant        (ro_grant),
    .fu_done         (fu_done),
    .wb_grant        (wb_grant),
    .wb_en           (wb_en),
    .wb_rd           (wb_rd),
    .busy_o          (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [2:0] fu, input logic [4:0] rd, input logic wr,
                       input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2);
    issue_valid     = 1'b1;
    issue_fu        = fu;
    issue_rd        = rd;
    issue_reg_write = wr;
    issue_rs1       = s1;
    issue_use_rs1   = u1;
    issue_rs2       = s2;
    issue_use_rs2   = u2;
  endtask

  task automatic noissue();
    issue_valid     = 1'b0;
    issue_fu        = '0;
    issue_rd        = '0;
    issue_reg_write = 1'b0;
    issue_rs1       = '0;
    issue_use_rs1   = 1'b0;
    issue_rs2       = '0;
    issue_use_rs2   = 1'b0;
  endtask

  // Register-file write monitor: every enabled write must match the next expected rd.
  always @(negedge clk) begin
    if (rst === 1'b1 && wb_en === 1'b1) begin
      if (exp_q.size() == 0) check("wb_unexpected", 32'(wb_rd), 32'hFFFF_FFFF);
      else check("wb_rd_seq", 32'(wb_rd), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b0;
    fu_done = '1;
    noissue();

    // Reset
    cyc(); cyc();
    settle();
    check("rst_busy", busy_o, 5'b0);
    check("rst_wb_grant", wb_grant, 5'b0);
    check("rst_ro_grant", ro_grant, 5'b0);
    check("rst_ready_idle", issue_ready, 1'b0);
    issue(FU_MUL, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    settle();
    check("rst_ready_valid", issue_ready, 1'b1);
    rst = 1'b1;
    fu_done = '0;
    noissue();

    // RAW: ALU waits on MUL result x5
    exp_q.push_back(5'd5); exp_q.push_back(5'd6);
    cyc(); issue(FU_MUL, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("raw_mul_ready", issue_ready, 1'b1);
    cyc(); issue(FU_ALU, 5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0); settle();
    check("raw_mul_ro", ro_grant, 5'b00100);
    check("raw_alu_ready", issue_ready, 1'b1);
    cyc(); noissue(); settle();
    check("raw_alu_wait", ro_grant, 5'b0);
    check("raw_busy", busy_o, 5'b00101);
    cyc(); fu_done = 5'b00100; settle();
    check("raw_mul_wb", wb_grant, 5'b00100);
    check("raw_mul_wb_rd", wb_rd, 5'd5);
    check("raw_alu_still_wait", ro_grant, 5'b0);
    cyc(); fu_done = '0; settle();
    check("raw_alu_ro", ro_grant, 5'b00001);
    check("raw_busy2", busy_o, 5'b00001);
    cyc(); fu_done = 5'b00001; settle();
    check("raw_alu_wb", wb_grant, 5'b00001);
    check("raw_alu_wb_rd", wb_rd, 5'd6);
    cyc(); fu_done = '0; settle();
    check("raw_idle", busy_o, 5'b0);

    // WAW and structural hazards
    exp_q.push_back(5'd5); exp_q.push_back(5'd5);
    issue(FU_MUL, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("waw_mul_ready", issue_ready, 1'b1);
    cyc(); issue(FU_DIV, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("waw_div_blocked", issue_ready, 1'b0);
    check("waw_mul_ro", ro_grant, 5'b00100);
    issue(FU_MUL, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("struct_mul_blocked", issue_ready, 1'b0);
    cyc(); issue(FU_DIV, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); fu_done = 5'b00100; settle();
    check("waw_same_cycle_blocked", issue_ready, 1'b0);
    check("waw_mul_wb", wb_grant, 5'b00100);
    cyc(); fu_done = '0; settle();
    check("waw_div_ready", issue_ready, 1'b1);
    cyc(); noissue(); settle();
    check("waw_div_ro", ro_grant, 5'b01000);
    cyc(); fu_done = 5'b01000; settle();
    check("waw_div_wb", wb_grant, 5'b01000);
    check("waw_div_wb_rd", wb_rd, 5'd5);
    cyc(); fu_done = '0; settle();
    check("waw_idle", busy_o, 5'b0);

    // WAR: MEM writing x7 must wait for ALU to read x7
    exp_q.push_back(5'd3); exp_q.push_back(5'd7); exp_q.push_back(5'd10);
    issue(FU_DIV, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("war_div_ready", issue_ready, 1'b1);
    cyc(); issue(FU_ALU, 5'd10, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1); settle();
    check("war_alu_ready", issue_ready, 1'b1);
    cyc(); issue(FU_MEM, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("war_mem_ready", issue_ready, 1'b1);
    check("war_alu_blocked_ro", ro_grant, 5'b0);
    cyc(); noissue(); settle();
    check("war_mem_ro", ro_grant, 5'b00010);
    cyc(); fu_done = 5'b00010; settle();
    check("war_mem_held", wb_grant, 5'b0);
    cyc(); settle();
    check("war_mem_held2", wb_grant, 5'b0);
    cyc(); fu_done = 5'b01010; settle();
    check("war_div_wb", wb_grant, 5'b01000);
    check("war_div_wb_rd", wb_rd, 5'd3);
    cyc(); fu_done = 5'b00010; settle();
    check("war_alu_ro", ro_grant, 5'b00001);
    check("war_mem_held3", wb_grant, 5'b0);
    cyc(); settle();
    check("war_mem_wb", wb_grant, 5'b00010);
    check("war_mem_wb_rd", wb_rd, 5'd7);
    cyc(); fu_done = 5'b00001; settle();
    check("war_alu_wb", wb_grant, 5'b00001);
    cyc(); fu_done = '0; settle();
    check("war_idle", busy_o, 5'b0);

    // Arbitration: ALU beats MUL in the same cycle
    exp_q.push_back(5'd11); exp_q.push_back(5'd12);
    issue(FU_ALU, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("arb_alu_ready", issue_ready, 1'b1);
    cyc(); issue(FU_MUL, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("arb_mul_ready", issue_ready, 1'b1);
    cyc(); noissue(); settle();
    cyc(); fu_done = 5'b00101; settle();
    check("arb_first", wb_grant, 5'b00001);
    check("arb_first_rd", wb_rd, 5'd11);
    cyc(); fu_done = 5'b00100; settle();
    check("arb_second", wb_grant, 5'b00100);
    check("arb_second_rd", wb_rd, 5'd12);
    cyc(); fu_done = '0; settle();
    check("arb_idle", busy_o, 5'b0);

    // x0 destination is never tracked
    issue(FU_ALU, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("x0_alu_ready", issue_ready, 1'b1);
    cyc(); issue(FU_MEM, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0); settle();
    check("x0_no_waw", issue_ready, 1'b1);
    cyc(); noissue(); settle();
    check("x0_rs1_ready", ro_grant, 5'b00010);
    cyc(); fu_done = 5'b00011; settle();
    check("x0_wb_grant", wb_grant, 5'b00001);
    check("x0_wb_en", wb_en, 1'b0);
    cyc(); fu_done = 5'b00010; settle();
    check("x0_wb_grant2", wb_grant, 5'b00010);
    check("x0_wb_en2", wb_en, 1'b0);
    cyc(); fu_done = '0;

    // Bypass: ALU reads x9 in the cycle MUL writes x9 back
    exp_q.push_back(5'd9); exp_q.push_back(5'd13);
    issue(FU_MUL, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("byp_mul_ready", issue_ready, 1'b1);
    cyc(); noissue(); settle();
    check("byp_mul_ro", ro_grant, 5'b00100);
    cyc(); fu_done = 5'b00100; issue(FU_ALU, 5'd13, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0); settle();
    check("byp_alu_ready", issue_ready, 1'b1);
    check("byp_mul_wb", wb_grant, 5'b00100);
    check("byp_mul_wb_rd", wb_rd, 5'd9);
    cyc(); fu_done = '0; noissue(); settle();
    check("byp_alu_ro", ro_grant, 5'b00001);
    cyc(); fu_done = 5'b00001; settle();
    check("byp_alu_wb", wb_grant, 5'b00001);
    check("byp_alu_wb_rd", wb_rd, 5'd13);
    cyc(); fu_done = '0; settle();
    check("byp_idle", busy_o, 5'b0);

    // Reset mid-operation discards in-flight state
    issue(FU_MUL, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc(); noissue(); rst = 1'b0; settle();
    check("mid_busy_before", busy_o, 5'b00100);
    cyc(); rst = 1'b1; settle();
    check("mid_busy_after", busy_o, 5'b0);
    issue(FU_DIV, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); settle();
    check("mid_rrs_cleared", issue_ready, 1'b1);
    noissue();
    cyc(); cyc();

    check("wb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
